// File: rtl/pll_reset_sequencer_pkg.sv
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and helpers for the PLL power-up / reset
//               sequencer: state encoding, counter width helper and the
//               retry counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    // Sequencer states. Explicit 3-bit encoding keeps the register width fixed.
    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_PLL_PWR   = 3'd1,
        ST_PLL_RST   = 3'd2,
        ST_LOCK_WAIT = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAIL      = 3'd6
    } pll_seq_state_t;

    // Width of the saturating retry counter exported on RETRY_CNT.
    localparam int c_RETRY_W = 2;

    // Width of the shared phase down-counter: enough bits to hold the
    // largest of the timing parameters.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
// ============================================================================
// Module      : pll_reset_sequencer_if
// Description : Signal bundle between the sequencer and the PLL / core.
//               master : sequencer side (drives PLL controls and core reset)
//               slave  : environment side (drives locks and rearm)
//               Inputs : pll1_lock, pll2_lock (async), rearm (1-cycle pulse)
//               Outputs: pll1_pd, pll1_rst, pll2_pd, pll2_rst, sys_rstn,
//                        ready, fail, retry_cnt[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pll_reset_sequencer_if;

    logic                              pll1_lock;
    logic                              pll2_lock;
    logic                              rearm;
    logic                              pll1_pd;
    logic                              pll1_rst;
    logic                              pll2_pd;
    logic                              pll2_rst;
    logic                              sys_rstn;
    logic                              ready;
    logic                              fail;
    logic [pll_seq_pkg::c_RETRY_W-1:0] retry_cnt;

    modport master (
        input  pll1_lock, pll2_lock, rearm,
        output pll1_pd, pll1_rst, pll2_pd, pll2_rst,
        output sys_rstn, ready, fail, retry_cnt
    );

    modport slave (
        output pll1_lock, pll2_lock, rearm,
        input  pll1_pd, pll1_rst, pll2_pd, pll2_rst,
        input  sys_rstn, ready, fail, retry_cnt
    );

endinterface

`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for an asynchronous level input,
//               asynchronously reset to 0.
//               Ports: clk, rst_n (async active-low), d (async in), q (sync out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Powers up and resets PLL1 (and optionally PLL2), waits for a
//               stable qualified lock, then releases the core reset. Lock loss
//               or lock timeout re-runs the PLL reset with bounded retries.
//               Ports: clk, rst_n (async active-low),
//                      bus (pll_reset_sequencer_if.master)
//               Build option: PLL2_EN - sequence PLL2 alongside PLL1 and
//               require both locks; otherwise PLL2 stays powered down.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PWR_WAIT     = 1024,
    parameter int PLL_RST_CYC  = 64,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int REL_DLY      = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_reset_sequencer_if.master  bus
);

    localparam int c_CNT_W  = cnt_width(PWR_WAIT, PLL_RST_CYC, LOCK_STABLE,
                                        LOCK_TIMEOUT, REL_DLY);
    localparam int c_STAB_W = $clog2(LOCK_STABLE + 1);
    localparam logic [c_STAB_W-1:0]  c_STAB_LAST = c_STAB_W'(LOCK_STABLE - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);

    pll_seq_state_t          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [c_STAB_W-1:0]     r_stab, w_stab_nxt;
    logic [c_RETRY_W-1:0]    r_retry, w_retry_nxt;
    logic                    r_low_prev, w_low_prev_nxt;
    logic                    w_retry_req;
    logic                    w_qlock;
    logic                    w_lock1;
    logic                    r_pd, r_rst, r_srn, r_ready, r_fail;
    logic                    w_pd, w_rst, w_srn, w_ready, w_fail;

    sync_2ff u_sync1 (.clk(clk), .rst_n(rst_n), .d(bus.pll1_lock), .q(w_lock1));

`ifdef PLL2_EN
    logic w_lock2;
    sync_2ff u_sync2 (.clk(clk), .rst_n(rst_n), .d(bus.pll2_lock), .q(w_lock2));
    assign w_qlock = w_lock1 & w_lock2;
`else
    assign w_qlock = w_lock1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_PWR_WAIT;
            r_cnt      <= c_CNT_W'(PWR_WAIT - 1);
            r_stab     <= '0;
            r_retry    <= '0;
            r_low_prev <= 1'b0;
            r_pd       <= 1'b1;
            r_rst      <= 1'b1;
            r_srn      <= 1'b0;
            r_ready    <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stab     <= w_stab_nxt;
            r_retry    <= w_retry_nxt;
            r_low_prev <= w_low_prev_nxt;
            r_pd       <= w_pd;
            r_rst      <= w_rst;
            r_srn      <= w_srn;
            r_ready    <= w_ready;
            r_fail     <= w_fail;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_stab_nxt     = '0;
        w_retry_nxt    = r_retry;
        w_retry_req    = 1'b0;
        // Only a low in RUN can start the two-cycle loss window.
        w_low_prev_nxt = (r_state == ST_RUN) && !w_qlock;

        case (r_state)
            ST_PWR_WAIT: if (r_cnt == '0) w_state_nxt = ST_PLL_PWR;
            ST_PLL_PWR:  w_state_nxt = ST_PLL_RST;
            ST_PLL_RST:  if (r_cnt == '0) w_state_nxt = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
                w_stab_nxt = w_qlock ? r_stab + 1'b1 : '0;
                // Stability is tested first so it wins over a same-cycle timeout.
                if (w_qlock && (r_stab == c_STAB_LAST))
                    w_state_nxt = ST_RELEASE;
                else if (r_cnt == '0)
                    w_retry_req = 1'b1;
            end
            ST_RELEASE: begin
                // A lock drop beats the release delay expiring in the same cycle.
                if (!w_qlock)
                    w_retry_req = 1'b1;
                else if (r_cnt == '0)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: if (!w_qlock && r_low_prev) w_retry_req = 1'b1;
            ST_FAIL: begin
                if (bus.rearm) begin
                    w_state_nxt = ST_PLL_PWR;
                    w_retry_nxt = '0;
                end
            end
            default: w_state_nxt = ST_PWR_WAIT;
        endcase

        if (w_retry_req) begin
            if (r_retry < c_MAX_RETRY) begin
                w_retry_nxt = r_retry + 1'b1;
                w_state_nxt = ST_PLL_RST;
            end else begin
                w_state_nxt = ST_FAIL;
            end
        end

        // Reload the phase counter with the new state's duration minus one.
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                ST_PWR_WAIT:  w_cnt_nxt = c_CNT_W'(PWR_WAIT - 1);
                ST_PLL_RST:   w_cnt_nxt = c_CNT_W'(PLL_RST_CYC - 1);
                ST_LOCK_WAIT: w_cnt_nxt = c_CNT_W'(LOCK_TIMEOUT - 1);
                ST_RELEASE:   w_cnt_nxt = c_CNT_W'(REL_DLY - 1);
                default:      w_cnt_nxt = '0;
            endcase
        end
    end

    // Outputs are registered from the next state so they track the state
    // register on the same edge.
    always_comb begin
        w_pd    = 1'b1;
        w_rst   = 1'b1;
        w_srn   = 1'b0;
        w_ready = 1'b0;
        w_fail  = 1'b0;
        case (w_state_nxt)
            ST_PLL_PWR, ST_PLL_RST: w_pd = 1'b0;
            ST_LOCK_WAIT, ST_RELEASE: begin
                w_pd  = 1'b0;
                w_rst = 1'b0;
            end
            ST_RUN: begin
                w_pd    = 1'b0;
                w_rst   = 1'b0;
                w_srn   = 1'b1;
                w_ready = 1'b1;
            end
            ST_FAIL: w_fail = 1'b1;
            default: ;
        endcase
    end

    assign bus.pll1_pd   = r_pd;
    assign bus.pll1_rst  = r_rst;
    assign bus.sys_rstn  = r_srn;
    assign bus.ready     = r_ready;
    assign bus.fail      = r_fail;
    assign bus.retry_cnt = r_retry;

`ifdef PLL2_EN
    assign bus.pll2_pd   = r_pd;
    assign bus.pll2_rst  = r_rst;
`else
    assign bus.pll2_pd   = 1'b1;
    assign bus.pll2_rst  = 1'b1;
`endif

endmodule

`default_nettype wire

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Power-up and reset sequencer sitting directly downstream of the chip IO power ring. Once core and PLL analog supplies are up, it powers up and resets PLL1/PLL2, waits for stable lock, and then releases the synchronous system reset to the core. It re-runs the PLL sequence on loss of lock, with bounded retries.

## Interface
- `PWR_WAIT`, default 1024: CLK cycles from reset release to PLL power-up (supply settle).
- `PLL_RST_CYC`, default 64: cycles PLL reset is held after power-up.
- `LOCK_STABLE`, default 256: consecutive cycles all enabled locks must be high.
- `LOCK_TIMEOUT`, default 65535: maximum cycles in LOCK_WAIT.
- `REL_DLY`, default 16: cycles from lock-qualified to SYS_RSTN deassert.
- `MAX_RETRY`, default 3: lock-loss/timeout retries before FAIL.
- `CLK` in 1: free-running reference clock (crystal, not PLL output).
- `RSTN` in 1: asynchronous active-low reset.
- `PLL1_LOCK` in 1: PLL1 lock indicator, asynchronous.
- `PLL2_LOCK` in 1: PLL2 lock indicator, asynchronous (ignored without PLL2_EN).
- `REARM` in 1: single-cycle pulse; leaves FAIL and restarts at PLL_PWR.
- `PLL1_PD` out 1: PLL1 power-down, active-high.
- `PLL1_RST` out 1: PLL1 reset, active-high.
- `PLL2_PD` out 1: PLL2 power-down.
- `PLL2_RST` out 1: PLL2 reset.
- `SYS_RSTN` out 1: core reset, active-low.
- `READY` out 1: high only in RUN.
- `FAIL` out 1: high only in FAIL.
- `RETRY_CNT` out 2: retries consumed, saturating.

## Operation
- States: PWR_WAIT → PLL_PWR → PLL_RST → LOCK_WAIT → RELEASE → RUN; FAIL.
- One down-counter, width `$clog2(max param + 1)`, reloaded on every state entry.
- PWR_WAIT: all PD/RST outputs = 1, SYS_RSTN = 0. Move to PLL_PWR after PWR_WAIT cycles.
- PLL_PWR: PD = 0, RST = 1 for exactly 1 cycle, then PLL_RST.
- PLL_RST: RST = 1 for PLL_RST_CYC cycles, then LOCK_WAIT with RST = 0.
- LOCK_WAIT:
  - Qualified lock = AND of the synchronized locks of the enabled PLLs.
  - A stability counter counts consecutive qualified cycles and clears on any low cycle.
  - Reaching LOCK_STABLE → RELEASE.
  - Timeout → retry.
- RELEASE: SYS_RSTN stays 0 for REL_DLY cycles. Any qualified-lock drop → retry. On completion → RUN.
- RUN: SYS_RSTN = 1, READY = 1. A qualified-lock low for 2 consecutive synchronized cycles → retry. SYS_RSTN goes 0 in the same cycle the state leaves RUN.
- Retry rule:
  - If RETRY_CNT < MAX_RETRY: increment, then go to PLL_RST (PD stays 0, RST = 1, SYS_RSTN = 0).
  - Otherwise go to FAIL.
- FAIL: PD = 1, RST = 1, SYS_RSTN = 0.
  - REARM → PLL_PWR, RETRY_CNT cleared.
  - REARM in any other state is ignored.
- RETRY_CNT clears only on RSTN or REARM. It is never cleared by reaching RUN.

## Timing
- Reset values (RSTN low, immediate/async): state PWR_WAIT, PD = RST = 1, SYS_RSTN = 0, READY = 0, FAIL = 0, RETRY_CNT = 0.
- Lock inputs pass a 2-flop synchronizer, giving 2-cycle input latency.
- All outputs are registered and change in the cycle following the state transition.
- Nominal lock latency, with lock high from LOCK_WAIT entry: 2 + LOCK_STABLE cycles in LOCK_WAIT, plus REL_DLY, to SYS_RSTN = 1.
- Simultaneous events:
  - Timeout and stability reached in the same cycle: stability wins.
  - Lock drop and REL_DLY expiry in the same cycle: retry wins.
- RSTN asserted mid-sequence: immediate return to the reset values; the full sequence restarts from PWR_WAIT.

## Configuration
- `PLL2_EN` defined: PLL2 outputs are sequenced identically to PLL1, and qualified lock = PLL1 & PLL2.
- `PLL2_EN` undefined:
  - PLL2_PD = 1 and PLL2_RST = 1, constant.
  - PLL2_LOCK is unused, with no synchronizer instantiated.
  - Qualified lock = PLL1 only.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum `pll_seq_state_t`;
  - the counter width function;
  - the retry counter width constant.
- Sub-module `sync_2ff`: a 2-flop synchronizer, reset to 0, instantiated per lock input.

## Test plan
- Defaults; PLL1_LOCK = 1 rises 10 cycles into LOCK_WAIT → SYS_RSTN rises exactly LOCK_STABLE + REL_DLY + 12 cycles after LOCK_WAIT entry; READY = 1; RETRY_CNT = 0.
- Lock glitches low 1 cycle at stability count 200 → stability restarts; SYS_RSTN is delayed by 201 extra cycles.
- Lock never rises → 4 timeouts total (3 retries), then FAIL = 1, PD = 1, RETRY_CNT = 3. REARM pulse → PLL_PWR, RETRY_CNT = 0.
- In RUN, drop lock 1 cycle → stays RUN. Drop 2 cycles → SYS_RSTN = 0 next cycle, PLL_RST entered, RETRY_CNT = 1.
- RSTN pulsed low during RELEASE → all outputs return to reset values asynchronously; the PWR_WAIT count restarts at 1024.
- Built with `PLL2_EN` and PLL2_LOCK held 0 → timeout path taken. Built without `PLL2_EN` → PLL2_PD = 1 constant and sequencing completes on PLL1 alone.
